// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the IF stage.
// Picks the next PC from prioritised redirects (trap, return, jump, branch)
// or the sequential address. A circular return-address stack predicts
// returns. Misaligned redirect targets are turned into a trap redirect.
//
// Ports:
//   clk, rstn      clock; asynchronous active-low reset
//   we             update enable; PC and RAS hold when low
//   trap           redirect to TRAP_ADDR, flush the RAS
//   ret, ret_addr  return: pop the RAS, or use ret_addr when it is empty
//   jump, jump_addr, call   jump; call also pushes the return address
//   branch, branch_addr     taken branch
//   instr_addr     current PC (low ALIGN bits always zero)
//   misalign       one-cycle pulse: the last selected target was misaligned
//   bad_addr       raw misaligned target captured with misalign
//   ras_empty, ras_full     RAS occupancy flags
module pc_gen #(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_ADDR = 32'h0100_0000,
   parameter logic [XLEN-1:0] TRAP_ADDR  = 32'h0000_0100,
   parameter int unsigned     ALIGN      = 2,
   parameter int unsigned     RAS_DEPTH  = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            we,
   input  logic            trap,
   input  logic            ret,
   input  logic [XLEN-1:0] ret_addr,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_addr,
   input  logic            call,
   input  logic            branch,
   input  logic [XLEN-1:0] branch_addr,
   output logic [XLEN-1:0] instr_addr,
   output logic            misalign,
   output logic [XLEN-1:0] bad_addr,
   output logic            ras_empty,
   output logic            ras_full
);

   localparam int unsigned      PW      = XLEN - ALIGN;
   localparam int unsigned      PTRW    = $clog2(RAS_DEPTH);
   localparam int unsigned      CNTW    = PTRW + 1;
   localparam logic [CNTW-1:0]  CNT_MAX = CNTW'(RAS_DEPTH);
   localparam logic [ALIGN-1:0] ZPAD    = '0;

   logic [PW-1:0]   pc_reg;
   logic [PW-1:0]   ras_mem [RAS_DEPTH];
   logic [PTRW-1:0] top;
   logic [CNTW-1:0] count;

   logic [XLEN-1:0] seq;
   logic [XLEN-1:0] tgt;
   logic [XLEN-1:0] next_pc;
   logic [PW-1:0]   ras_top;
   logic            redirect;
   logic            bad;
   logic            do_pop;
   logic            do_push;

   assign instr_addr = {pc_reg, ZPAD};
   assign ras_empty  = (count == '0);
   assign ras_full   = (count == CNT_MAX);

   always_comb begin
      seq      = instr_addr + XLEN'(4);
      ras_top  = ras_mem[top];
      do_pop   = ret & ~trap & (count != '0);
      do_push  = jump & call & ~trap & ~ret;
      tgt      = seq;
      redirect = 1'b0;
      if (trap) begin
         tgt = TRAP_ADDR;
      end else if (ret) begin
         tgt      = (count != '0) ? {ras_top, ZPAD} : ret_addr;
         redirect = 1'b1;
      end else if (jump) begin
         tgt      = jump_addr;
         redirect = 1'b1;
      end else if (branch) begin
         tgt      = branch_addr;
         redirect = 1'b1;
      end
      // Only external targets can be misaligned; RAS entries are stored
      // without the low bits, and seq/TRAP_ADDR are aligned by construction.
      bad     = redirect & (tgt[ALIGN-1:0] != '0);
      next_pc = bad ? TRAP_ADDR : tgt;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_reg   <= RESET_ADDR[XLEN-1:ALIGN];
         top      <= '0;
         count    <= '0;
         misalign <= 1'b0;
         bad_addr <= '0;
      end else begin
         misalign <= we & bad;
         if (we) begin
            pc_reg <= next_pc[XLEN-1:ALIGN];
            if (bad) begin
               bad_addr <= tgt;
            end
            if (trap) begin
               count <= '0;
            end else if (do_pop) begin
               top   <= top - 1'b1;
               count <= count - 1'b1;
            end else if (do_push) begin
               // Pointer wraps freely; when full the oldest entry is overwritten.
               top <= top + 1'b1;
               if (count != CNT_MAX) begin
                  count <= count + 1'b1;
               end
            end
         end
      end
   end

   // Stack storage carries no reset: entries are only read while count > 0.
   always_ff @(posedge clk) begin
      if (we && do_push) begin
         ras_mem[top + 1'b1] <= seq[XLEN-1:ALIGN];
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: self-checking bench for pc_gen. Two instances (ALIGN=2 and
// ALIGN=1) share stimulus; a behavioural model (bounded stack array) tracks
// both and is compared every cycle, with directed literal checks on top.
module tb_pc_gen;

   localparam logic [31:0] RST_A  = 32'h0100_0000;
   localparam logic [31:0] TRAP_A = 32'h0000_0100;
   localparam int          DEPTH  = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        we, trap, ret, jump, call, branch;
   logic [31:0] ret_addr, jump_addr, branch_addr;

   logic [31:0] a0, b0, a1, b1;
   logic        mis0, emp0, full0, mis1, emp1, full1;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // model state, index 0 = ALIGN 2, index 1 = ALIGN 1
   logic [31:0] m_pc  [2];
   logic [31:0] m_bad [2];
   logic        m_mis [2];
   logic [31:0] m_stk [2][DEPTH];
   int          m_n   [2];

   always #5 clk = ~clk;

   pc_gen #(.XLEN(32), .RESET_ADDR(RST_A), .TRAP_ADDR(TRAP_A), .ALIGN(2), .RAS_DEPTH(DEPTH)) u0 (
      .clk(clk), .rstn(rstn), .we(we), .trap(trap), .ret(ret), .ret_addr(ret_addr),
      .jump(jump), .jump_addr(jump_addr), .call(call), .branch(branch), .branch_addr(branch_addr),
      .instr_addr(a0), .misalign(mis0), .bad_addr(b0), .ras_empty(emp0), .ras_full(full0));

   pc_gen #(.XLEN(32), .RESET_ADDR(RST_A), .TRAP_ADDR(TRAP_A), .ALIGN(1), .RAS_DEPTH(DEPTH)) u1 (
      .clk(clk), .rstn(rstn), .we(we), .trap(trap), .ret(ret), .ret_addr(ret_addr),
      .jump(jump), .jump_addr(jump_addr), .call(call), .branch(branch), .branch_addr(branch_addr),
      .instr_addr(a1), .misalign(mis1), .bad_addr(b1), .ras_empty(emp1), .ras_full(full1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_pc[i]  = RST_A;
         m_bad[i] = '0;
         m_mis[i] = 1'b0;
         m_n[i]   = 0;
      end
   endtask

   task automatic model_push(input int i, input logic [31:0] v);
      if (m_n[i] == DEPTH) begin
         for (int k = 0; k < DEPTH - 1; k++) m_stk[i][k] = m_stk[i][k+1];
         m_stk[i][DEPTH-1] = v;
      end else begin
         m_stk[i][m_n[i]] = v;
         m_n[i]++;
      end
   endtask

   task automatic model_step(input int i, input logic [31:0] mask);
      logic [31:0] seq, tgt;
      bit          red;
      seq = m_pc[i] + 32'd4;
      tgt = seq;
      red = 1'b0;
      if (!we) begin
         m_mis[i] = 1'b0;
         return;
      end
      if (trap) begin
         tgt    = TRAP_A;
         m_n[i] = 0;
      end else if (ret) begin
         red = 1'b1;
         if (m_n[i] > 0) begin
            m_n[i]--;
            tgt = m_stk[i][m_n[i]];
         end else begin
            tgt = ret_addr;
         end
      end else if (jump) begin
         red = 1'b1;
         tgt = jump_addr;
         if (call) model_push(i, seq);
      end else if (branch) begin
         red = 1'b1;
         tgt = branch_addr;
      end
      if (red && ((tgt & mask) != 0)) begin
         m_mis[i] = 1'b1;
         m_bad[i] = tgt;
         m_pc[i]  = TRAP_A;
      end else begin
         m_mis[i] = 1'b0;
         m_pc[i]  = tgt;
      end
   endtask

   initial model_reset();

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         model_reset();
      end else begin
         model_step(0, 32'h3);
         model_step(1, 32'h1);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("u0.instr_addr", a0, m_pc[0]);
         check("u0.misalign", 32'(mis0), 32'(m_mis[0]));
         check("u0.bad_addr", b0, m_bad[0]);
         check("u0.ras_empty", 32'(emp0), 32'(m_n[0] == 0));
         check("u0.ras_full", 32'(full0), 32'(m_n[0] == DEPTH));
         check("u1.instr_addr", a1, m_pc[1]);
         check("u1.misalign", 32'(mis1), 32'(m_mis[1]));
         check("u1.bad_addr", b1, m_bad[1]);
         check("u1.ras_empty", 32'(emp1), 32'(m_n[1] == 0));
         check("u1.ras_full", 32'(full1), 32'(m_n[1] == DEPTH));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ctl(input logic t, input logic r, input logic j, input logic c, input logic b,
                      input logic [31:0] ja, input logic [31:0] ba, input logic [31:0] ra);
      trap = t; ret = r; jump = j; call = c; branch = b;
      jump_addr = ja; branch_addr = ba; ret_addr = ra;
   endtask

   task automatic idle();
      ctl(0, 0, 0, 0, 0, '0, '0, '0);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] v;
      v = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) v = 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) v = v | 32'($urandom_range(1, 3));
      return v;
   endfunction

   initial begin
      rstn = 1'b0;
      we   = 1'b0;
      idle();
      tick();
      chk_en = 1'b1;
      tick();
      check("lit.reset_pc", a0, 32'h0100_0000);
      check("lit.reset_empty", 32'(emp0), 32'd1);
      check("lit.reset_full", 32'(full0), 32'd0);
      check("lit.reset_bad", b0, 32'h0);

      // reset release and increment
      rstn = 1'b1;
      we   = 1'b1;
      tick(); check("lit.inc1", a0, 32'h0100_0004);
      tick(); check("lit.inc2", a0, 32'h0100_0008);
      tick(); check("lit.inc3", a0, 32'h0100_000C);
      we = 1'b0;
      tick(); check("lit.hold", a0, 32'h0100_000C);
      we = 1'b1;
      tick(); check("lit.inc4", a0, 32'h0100_0010);

      // call / return
      ctl(0, 0, 1, 1, 0, 32'h4000, '0, '0);
      tick(); check("lit.call", a0, 32'h4000);
      check("lit.call_nonempty", 32'(emp0), 32'd0);
      ctl(0, 1, 0, 0, 0, '0, '0, 32'h9990);
      tick(); check("lit.ret", a0, 32'h0100_0014);
      check("lit.ret_empty", 32'(emp0), 32'd1);
      ctl(0, 1, 0, 0, 0, '0, '0, 32'h5000);
      tick(); check("lit.ret_fallback", a0, 32'h5000);

      // priority
      ctl(0, 0, 1, 1, 0, 32'h6000, '0, '0);
      tick(); check("lit.call2", a0, 32'h6000);
      ctl(1, 1, 1, 1, 1, 32'h2000, 32'h3000, 32'h5000);
      tick(); check("lit.trap_pri", a0, 32'h100);
      check("lit.trap_flush", 32'(emp0), 32'd1);
      ctl(0, 0, 1, 0, 1, 32'h2000, 32'h3000, '0);
      tick(); check("lit.jump_pri", a0, 32'h2000);

      // RAS overflow: return points A..E = 2004, 7004, 7104, 7204, 7304
      for (int k = 0; k < 5; k++) begin
         ctl(0, 0, 1, 1, 0, 32'h7000 + 32'(k) * 32'h100, '0, '0);
         tick();
      end
      check("lit.ras_full", 32'(full0), 32'd1);
      ctl(0, 1, 0, 0, 0, '0, '0, 32'h5000);
      tick(); check("lit.pop_e", a0, 32'h7304);
      tick(); check("lit.pop_d", a0, 32'h7204);
      tick(); check("lit.pop_c", a0, 32'h7104);
      tick(); check("lit.pop_b", a0, 32'h7004);
      tick(); check("lit.pop_fallback", a0, 32'h5000);

      // misalignment
      ctl(0, 0, 1, 0, 0, 32'h2002, '0, '0);
      tick();
      check("lit.mis_pc", a0, 32'h100);
      check("lit.mis_pulse", 32'(mis0), 32'd1);
      check("lit.mis_bad", b0, 32'h2002);
      check("lit.align1_pc", a1, 32'h2002);
      check("lit.align1_nomis", 32'(mis1), 32'd0);
      idle();
      tick();
      check("lit.mis_clear", 32'(mis0), 32'd0);
      check("lit.mis_next", a0, 32'h104);

      // wrap
      ctl(0, 0, 1, 0, 0, 32'hFFFF_FFFC, '0, '0);
      tick(); check("lit.wrap_pre", a0, 32'hFFFF_FFFC);
      idle();
      tick(); check("lit.wrap", a0, 32'h0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         we = ($urandom_range(0, 7) != 0);
         ctl(($urandom_range(0, 15) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), rand_addr(), rand_addr(), rand_addr());
         tick();
      end

      // asynchronous reset in mid-cycle
      we = 1'b1;
      ctl(0, 0, 1, 1, 0, 32'h8000, '0, '0);
      tick();
      #2;
      rstn = 1'b0;
      #1;
      check("lit.async_pc0", a0, 32'h0100_0000);
      check("lit.async_pc1", a1, 32'h0100_0000);
      check("lit.async_empty", 32'(emp0), 32'd1);
      tick();
      rstn = 1'b1;
      idle();
      tick();
      tick();
      chk_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the IF stage of the RISC-V core. It replaces the fixed 32-bit, 4-byte-aligned counter with a configurable address generator. Features:
- Configurable width, reset vector and alignment.
- Prioritised redirect sources: trap, return, jump, branch.
- A circular return-address stack (RAS) for call/return prediction.
- Misaligned-target detection with automatic trap redirect.

It sits between the control unit (which drives `we` and the redirect controls) and the instruction memory address port.

## Interface
Parameters:
- `XLEN`, 32, address width in bits.
- `RESET_ADDR`, 32'h0100_0000, PC value after reset; low `ALIGN` bits must be zero.
- `TRAP_ADDR`, 32'h0000_0100, redirect target for traps and misaligned targets.
- `ALIGN`, 2, number of forced-zero LSBs: 2 = 4-byte instructions, 1 = compressed.
- `RAS_DEPTH`, 4, RAS entries; power of two, minimum 2.

Ports:
- `clk`, in, 1, clock.
- `rstn`, in, 1, reset: asynchronous, active-low.
- `we`, in, 1, update enable (IF stage); when low the PC and RAS hold.
- `trap`, in, 1, take trap vector.
- `ret`, in, 1, return: pop RAS.
- `ret_addr`, in, XLEN, fallback return target, used only when the RAS is empty.
- `jump`, in, 1, unconditional redirect to `jump_addr`.
- `jump_addr`, in, XLEN, jump target.
- `call`, in, 1, qualifies `jump`: push the sequential address to the RAS.
- `branch`, in, 1, taken branch.
- `branch_addr`, in, XLEN, branch target.
- `instr_addr`, out, XLEN, current PC; low `ALIGN` bits are always 0.
- `misalign`, out, 1, one-cycle pulse: the selected target was misaligned.
- `bad_addr`, out, XLEN, misaligned target captured with the last `misalign`.
- `ras_empty`, out, 1, RAS holds no entries.
- `ras_full`, out, 1, RAS holds `RAS_DEPTH` entries.

## Operation
Storage:
- PC register is `XLEN-ALIGN` bits wide.
- `instr_addr = {pc_reg, ALIGN'b0}`.
- Sequential address `seq = instr_addr + 4`, computed modulo 2^XLEN (wraps from all-ones to 0).

Next-PC selection when `we=1`, in strict priority order:
1. `trap` → `TRAP_ADDR`.
2. `ret` → RAS top if non-empty; otherwise `ret_addr`.
3. `jump` → `jump_addr`.
4. `branch` → `branch_addr`.
5. No request → `seq`.

Misaligned targets:
- Applies to a selected target from priority 2–4 whose low `ALIGN` bits are non-zero.
- PC loads `TRAP_ADDR` instead of the target.
- `misalign` pulses for the following cycle.
- `bad_addr` captures the raw target.
- RAS side effects of that request are still applied.

RAS behaviour:
- Circular buffer: `RAS_DEPTH` entries of `XLEN-ALIGN` bits, plus a top pointer and a count of 0..`RAS_DEPTH`.
- **Push:** on `jump & call & ~trap & ~ret`, write `seq` at top+1. Count saturates at `RAS_DEPTH`. When full, the oldest entry is overwritten (pointer wraps).
- **Pop:** on `ret & ~trap` with count > 0, decrement top and count. A pop when empty changes nothing.
- **Trap flush:** `trap` sets count to 0; the pointer is unchanged.
- `ret` and `call` together: `ret` wins and no push occurs.

When `we=0`: all inputs are ignored, PC and RAS hold, and `misalign` is 0.

`ras_empty = (count==0)` and `ras_full = (count==RAS_DEPTH)`, both combinational from registered state.

## Timing
Reset (asynchronous, while `rstn=0`):
- `instr_addr = RESET_ADDR`.
- RAS count = 0, pointer = 0.
- `misalign = 0`, `bad_addr = 0`.
- `ras_empty = 1`, `ras_full = 0`.

Reset asserted mid-operation clears all state immediately, regardless of `clk`.

Latency:
- Selection is combinational from the inputs sampled at the `clk` edge with `we=1`.
- The new `instr_addr` is visible 1 cycle after that edge; there is no additional latency.
- `misalign` is registered: high for exactly the cycle in which `instr_addr` shows `TRAP_ADDR` as a result of the misalignment.
- RAS push and pop take effect at the same edge as the PC update.
- A `ret` in the cycle immediately after a `call` returns the just-pushed value.

No handshake exists; `we` is a pure enable and may toggle every cycle.

## Test plan
- **Reset and increment:** release `rstn`, `we=1` for 3 cycles → `instr_addr` = 0x0100_0000, 0x0100_0004, 0x0100_0008, 0x0100_000C. With `we=0`, the value holds.
- **Priority:** `trap=ret=jump=branch=1` → `TRAP_ADDR` (0x100) and RAS count 0. Then `jump=branch=1`, `jump_addr`=0x2000, `branch_addr`=0x3000 → 0x2000.
- **Call/return:** PC 0x0100_0010, `call+jump` to 0x4000, then `ret` → 0x4000, then 0x0100_0014, `ras_empty=1`. `ret` with an empty RAS and `ret_addr`=0x5000 → 0x5000.
- **RAS overflow** (`RAS_DEPTH`=4): 5 nested calls from return points A..E → `ras_full=1`; 4 rets yield E, D, C, B. The 5th ret uses `ret_addr`.
- **Misalignment:** `jump_addr`=0x2002 with `ALIGN`=2 → next `instr_addr`=0x100, `misalign=1` for one cycle, `bad_addr`=0x2002. With `ALIGN`=1, the same target is accepted.
- **Wrap and async reset:** PC 0xFFFF_FFFC with `we=1` → 0x0000_0000. Assert `rstn=0` mid-cycle → `instr_addr` becomes 0x0100_0000 before the next edge.
